// File: rtl/uart_rx_core_if.sv
// uart_rx_core_if: groups the UART receiver's serial input and its
// byte/strobe outputs into one bundle.
//   i_RX_Serial    - asynchronous serial line, idle high
//   o_RX_DV        - one-cycle strobe, o_RX_Byte valid
//   o_RX_Byte      - last correctly framed byte
//   o_RX_Active    - high while a frame is in progress
//   o_RX_Frame_Err - one-cycle strobe, stop bit sampled low
// Modports: slave = receiver core, master = line driver / byte consumer.
interface uart_rx_core_if;
  logic       i_RX_Serial;
  logic       o_RX_DV;
  logic [7:0] o_RX_Byte;
  logic       o_RX_Active;
  logic       o_RX_Frame_Err;

  modport slave (
    input  i_RX_Serial,
    output o_RX_DV, o_RX_Byte, o_RX_Active, o_RX_Frame_Err
  );

  modport master (
    output i_RX_Serial,
    input  o_RX_DV, o_RX_Byte, o_RX_Active, o_RX_Frame_Err
  );
endinterface

// File: rtl/uart_rx_core.sv
// uart_rx_core: 8N1 UART receiver, LSB first, mid-bit sampling.
//   i_Clock  - system clock, rising edge
//   i_Rst_L  - asynchronous active-low reset
//   rx_if    - uart_rx_core_if.slave (serial in, byte/strobe outputs)
// Parameters: CLK_FREQ (Hz), BAUD_RATE (bit/s); CLKS_PER_BIT = CLK_FREQ/BAUD_RATE.
// Build option: UART_RX_MAJORITY_EN enables 2-of-3 majority voting around
// every sample point; the decision moves one clock later and the whole
// schedule shifts with it, so bit centres do not drift.
module uart_rx_core #(
  parameter int CLK_FREQ  = 25000000,
  parameter int BAUD_RATE = 115200
) (
  input logic          i_Clock,
  input logic          i_Rst_L,
  uart_rx_core_if.slave rx_if
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
  localparam int MID          = (CLKS_PER_BIT - 1) / 2;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT) + 1;

`ifdef UART_RX_MAJORITY_EN
  localparam int START_PT = MID + 1;
`else
  localparam int START_PT = MID;
`endif

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BREAK = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       data_q, data_d;
  logic [7:0]       byte_q, byte_d;
  logic             dv_q, dv_d;
  logic             fe_q, fe_d;
  logic             active_q, active_d;
  logic             rx_m_q, rx_s_q;
  logic             samp;

  // Two-flop synchronizer; idle-high reset so no false start after reset.
  always_ff @(posedge i_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      rx_m_q <= 1'b1;
      rx_s_q <= 1'b1;
    end else begin
      rx_m_q <= rx_if.i_RX_Serial;
      rx_s_q <= rx_m_q;
    end
  end

`ifdef UART_RX_MAJORITY_EN
  // hist_q[0] = rx_s one clock ago, hist_q[1] = two clocks ago.
  logic [1:0] hist_q;
  always_ff @(posedge i_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L) hist_q <= 2'b11;
    else          hist_q <= {hist_q[0], rx_s_q};
  end
  assign samp = (rx_s_q & hist_q[0]) | (rx_s_q & hist_q[1]) | (hist_q[0] & hist_q[1]);
`else
  assign samp = rx_s_q;
`endif

  always_ff @(posedge i_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      data_q    <= '0;
      byte_q    <= '0;
      dv_q      <= 1'b0;
      fe_q      <= 1'b0;
      active_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      data_q    <= data_d;
      byte_q    <= byte_d;
      dv_q      <= dv_d;
      fe_q      <= fe_d;
      active_q  <= active_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + 1'b1;
    bit_idx_d = bit_idx_q;
    data_d    = data_q;
    byte_d    = byte_q;
    dv_d      = 1'b0;
    fe_d      = 1'b0;
    active_d  = active_q;
    case (state_q)
      S_IDLE: begin
        cnt_d     = '0;
        bit_idx_d = '0;
        if (!rx_s_q) begin
          state_d  = S_START;
          active_d = 1'b1;
        end
      end
      S_START: begin
        if (cnt_q == CNT_W'(START_PT)) begin
          cnt_d = '0;
          if (!samp) begin
            state_d = S_DATA;
          end else begin
            // Start bit did not survive to mid-bit: treat as a glitch.
            state_d  = S_IDLE;
            active_d = 1'b0;
          end
        end
      end
      S_DATA: begin
        if (cnt_q == CNT_W'(CLKS_PER_BIT - 1)) begin
          cnt_d             = '0;
          data_d[bit_idx_q] = samp;
          bit_idx_d         = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (cnt_q == CNT_W'(CLKS_PER_BIT - 1)) begin
          cnt_d    = '0;
          active_d = 1'b0;
          if (samp) begin
            byte_d  = data_q;
            dv_d    = 1'b1;
            state_d = S_IDLE;
          end else begin
            fe_d    = 1'b1;
            state_d = S_BREAK;
          end
        end
      end
      S_BREAK: begin
        // Line held low: wait for it to recover before arming for a start.
        cnt_d = '0;
        if (rx_s_q) state_d = S_IDLE;
      end
      default: begin
        state_d  = S_IDLE;
        cnt_d    = '0;
        active_d = 1'b0;
      end
    endcase
  end

  assign rx_if.o_RX_DV        = dv_q;
  assign rx_if.o_RX_Byte      = byte_q;
  assign rx_if.o_RX_Active    = active_q;
  assign rx_if.o_RX_Frame_Err = fe_q;

endmodule

// File: tb/tb_uart_rx_core.sv
// tb_uart_rx_core: self-checking bench for uart_rx_core. The line is
// driven bit by bit; a negedge monitor logs strobes, and each test task
// compares what was logged against bytes/timing derived from the 8N1 rules.
module tb_uart_rx_core;
  localparam int CLK_FREQ  = 25000000;
  localparam int BAUD_RATE = 115200;
  localparam int CPB       = CLK_FREQ / BAUD_RATE;
  localparam int MID       = (CPB - 1) / 2;
  localparam int LAT       = 3 + MID + 9 * CPB;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #20 clk = ~clk;

  uart_rx_core_if rx_if ();
  uart_rx_core #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD_RATE)) dut (
    .i_Clock(clk), .i_Rst_L(rst_n), .rx_if(rx_if));

  int checks = 0;
  int errors = 0;

  // Monitor state: cumulative, only written here.
  longint     cyc = 0;
  int         dv_cnt = 0, fe_cnt = 0, both_cnt = 0, dbl_cnt = 0, act_err = 0;
  int         act_starts = 0, act_run = 0, last_run = 0;
  logic [7:0] got_q[$];
  longint     dv_cyc_q[$];
  logic       dv_p = 0, fe_p = 0, act_p = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rx_if.o_RX_DV) begin
      dv_cnt++;
      got_q.push_back(rx_if.o_RX_Byte);
      dv_cyc_q.push_back(cyc);
      if (!(act_p && !rx_if.o_RX_Active)) act_err++;
    end
    if (rx_if.o_RX_Frame_Err) fe_cnt++;
    if (rx_if.o_RX_DV && rx_if.o_RX_Frame_Err) both_cnt++;
    if ((rx_if.o_RX_DV && dv_p) || (rx_if.o_RX_Frame_Err && fe_p)) dbl_cnt++;
    if (rx_if.o_RX_Active) begin
      if (!act_p) act_starts++;
      act_run++;
    end else if (act_p) begin
      last_run = act_run;
      act_run  = 0;
    end
    dv_p  = rx_if.o_RX_DV;
    fe_p  = rx_if.o_RX_Frame_Err;
    act_p = rx_if.o_RX_Active;
  end

  // All drive tasks are entered at a negedge and return at a negedge.
  task automatic drive_lvl(input logic v, input int n);
    rx_if.i_RX_Serial = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop, output longint t0);
    t0 = cyc + 1;  // posedge that first captures the start bit
    drive_lvl(1'b0, CPB);
    for (int i = 0; i < 8; i++) drive_lvl(b[i], CPB);
    drive_lvl(stop, CPB);
  endtask

  task automatic test_reset();
    rx_if.i_RX_Serial = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (rx_if.o_RX_DV !== 1'b0) begin errors++; $display("FAIL reset_dv got=%b exp=0", rx_if.o_RX_DV); end
    checks++; if (rx_if.o_RX_Byte !== 8'h00) begin errors++; $display("FAIL reset_byte got=%h exp=00", rx_if.o_RX_Byte); end
    checks++; if (rx_if.o_RX_Active !== 1'b0) begin errors++; $display("FAIL reset_active got=%b exp=0", rx_if.o_RX_Active); end
    checks++; if (rx_if.o_RX_Frame_Err !== 1'b0) begin errors++; $display("FAIL reset_fe got=%b exp=0", rx_if.o_RX_Frame_Err); end
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_single();
    int d0 = dv_cnt, f0 = fe_cnt, a0 = act_err;
    longint t0;
    send_frame(8'hA5, 1'b1, t0);
    drive_lvl(1'b1, 20);
    checks++; if (dv_cnt - d0 != 1) begin errors++; $display("FAIL single_dv_count got=%0d exp=1", dv_cnt - d0); end
    checks++; if (rx_if.o_RX_Byte !== 8'hA5) begin errors++; $display("FAIL single_byte got=%h exp=a5", rx_if.o_RX_Byte); end
    checks++; if (fe_cnt != f0) begin errors++; $display("FAIL single_fe got=%0d exp=0", fe_cnt - f0); end
    checks++; if (act_err != a0) begin errors++; $display("FAIL single_active_fall got=%0d exp=0", act_err - a0); end
  endtask

  task automatic test_back_to_back();
    int d0 = dv_cnt;
    longint t0, t1;
    send_frame(8'h00, 1'b1, t0);
    send_frame(8'hFF, 1'b1, t1);
    drive_lvl(1'b1, 20);
    checks++; if (dv_cnt - d0 != 2) begin errors++; $display("FAIL b2b_dv_count got=%0d exp=2", dv_cnt - d0); end
    if (dv_cnt - d0 == 2) begin
      longint l0 = dv_cyc_q[d0] - t0;
      longint l1 = dv_cyc_q[d0+1] - t1;
      checks++; if (got_q[d0] !== 8'h00) begin errors++; $display("FAIL b2b_byte0 got=%h exp=00", got_q[d0]); end
      checks++; if (got_q[d0+1] !== 8'hFF) begin errors++; $display("FAIL b2b_byte1 got=%h exp=ff", got_q[d0+1]); end
      checks++; if (l0 < LAT - 1 || l0 > LAT + 1) begin errors++; $display("FAIL b2b_lat0 got=%0d exp=%0d+-1", l0, LAT); end
      checks++; if (l1 < LAT - 1 || l1 > LAT + 1) begin errors++; $display("FAIL b2b_lat1 got=%0d exp=%0d+-1", l1, LAT); end
    end
  endtask

  task automatic test_start_glitch();
    int d0 = dv_cnt, f0 = fe_cnt, s0 = act_starts;
    longint t0;
    drive_lvl(1'b0, 50);
    drive_lvl(1'b1, 2 * CPB);
    checks++; if (dv_cnt != d0) begin errors++; $display("FAIL sglitch_dv got=%0d exp=0", dv_cnt - d0); end
    checks++; if (fe_cnt != f0) begin errors++; $display("FAIL sglitch_fe got=%0d exp=0", fe_cnt - f0); end
    checks++; if (act_starts - s0 != 1 || last_run > MID + 4) begin
      errors++; $display("FAIL sglitch_active starts=%0d run=%0d exp 1 run<=%0d", act_starts - s0, last_run, MID + 4); end
    send_frame(8'h3C, 1'b1, t0);
    drive_lvl(1'b1, 20);
    checks++; if (dv_cnt - d0 != 1 || rx_if.o_RX_Byte !== 8'h3C) begin
      errors++; $display("FAIL sglitch_next got=%0d/%h exp=1/3c", dv_cnt - d0, rx_if.o_RX_Byte); end
  endtask

  task automatic test_break();
    int d0 = dv_cnt, f0 = fe_cnt, s0;
    logic [7:0] prev = rx_if.o_RX_Byte;
    longint t0;
    send_frame(8'h3C, 1'b0, t0);
    s0 = act_starts;
    drive_lvl(1'b0, 3 * CPB);
    checks++; if (fe_cnt - f0 != 1) begin errors++; $display("FAIL break_fe got=%0d exp=1", fe_cnt - f0); end
    checks++; if (dv_cnt != d0) begin errors++; $display("FAIL break_dv got=%0d exp=0", dv_cnt - d0); end
    checks++; if (rx_if.o_RX_Byte !== prev) begin errors++; $display("FAIL break_byte got=%h exp=%h", rx_if.o_RX_Byte, prev); end
    checks++; if (act_starts != s0) begin errors++; $display("FAIL break_no_start got=%0d exp=0", act_starts - s0); end
    drive_lvl(1'b1, CPB);
    send_frame(8'h81, 1'b1, t0);
    drive_lvl(1'b1, 20);
    checks++; if (dv_cnt - d0 != 1 || rx_if.o_RX_Byte !== 8'h81) begin
      errors++; $display("FAIL break_next got=%0d/%h exp=1/81", dv_cnt - d0, rx_if.o_RX_Byte); end
  endtask

  task automatic test_reset_midframe();
    int d0;
    longint t0;
    logic [7:0] b = 8'hF0;
    drive_lvl(1'b0, CPB);
    for (int i = 0; i < 4; i++) drive_lvl(b[i], CPB);
    drive_lvl(b[4], CPB / 2);
    checks++; if (rx_if.o_RX_Active !== 1'b1) begin errors++; $display("FAIL rstmid_active_before got=%b exp=1", rx_if.o_RX_Active); end
    rst_n = 1'b0;
    #1;
    checks++; if ({rx_if.o_RX_DV, rx_if.o_RX_Active, rx_if.o_RX_Frame_Err} !== 3'b000 || rx_if.o_RX_Byte !== 8'h00) begin
      errors++; $display("FAIL rstmid_outputs got=%b%b%b/%h exp=000/00", rx_if.o_RX_DV, rx_if.o_RX_Active,
                         rx_if.o_RX_Frame_Err, rx_if.o_RX_Byte); end
    d0 = dv_cnt;
    @(negedge clk);
    drive_lvl(1'b1, 4);
    rst_n = 1'b1;
    drive_lvl(1'b1, 3 * CPB);
    checks++; if (dv_cnt != d0) begin errors++; $display("FAIL rstmid_no_dv got=%0d exp=0", dv_cnt - d0); end
    send_frame(8'h5A, 1'b1, t0);
    drive_lvl(1'b1, 20);
    checks++; if (dv_cnt - d0 != 1 || rx_if.o_RX_Byte !== 8'h5A) begin
      errors++; $display("FAIL rstmid_next got=%0d/%h exp=1/5a", dv_cnt - d0, rx_if.o_RX_Byte); end
  endtask

  task automatic test_mid_glitch();
    int d0 = dv_cnt;
    logic [7:0] exp;
`ifdef UART_RX_MAJORITY_EN
    exp = 8'h00;  // single-clock glitch outvoted
`else
    exp = 8'h08;  // glitch lands on the lone sample of bit 3
`endif
    drive_lvl(1'b0, CPB);
    for (int i = 0; i < 8; i++) begin
      if (i == 3) begin
        drive_lvl(1'b0, MID + 1);
        drive_lvl(1'b1, 1);
        drive_lvl(1'b0, CPB - MID - 2);
      end else drive_lvl(1'b0, CPB);
    end
    drive_lvl(1'b1, CPB);
    drive_lvl(1'b1, 20);
    checks++; if (dv_cnt - d0 != 1 || rx_if.o_RX_Byte !== exp) begin
      errors++; $display("FAIL mid_glitch got=%0d/%h exp=1/%h", dv_cnt - d0, rx_if.o_RX_Byte, exp); end
  endtask

  task automatic test_random();
    logic [7:0] exp_q[$];
    int d0 = dv_cnt;
    longint t0;
    for (int n = 0; n < 8; n++) begin
      logic [7:0] b = 8'($urandom);
      exp_q.push_back(b);
      send_frame(b, 1'b1, t0);
      drive_lvl(1'b1, $urandom_range(0, 30));
    end
    drive_lvl(1'b1, 20);
    checks++; if (dv_cnt - d0 != exp_q.size()) begin errors++; $display("FAIL rand_count got=%0d exp=%0d", dv_cnt - d0, exp_q.size()); end
    for (int n = 0; n < exp_q.size() && d0 + n < dv_cnt; n++) begin
      checks++; if (got_q[d0+n] !== exp_q[n]) begin errors++; $display("FAIL rand_byte%0d got=%h exp=%h", n, got_q[d0+n], exp_q[n]); end
    end
  endtask

  task automatic test_strobe_rules();
    checks++; if (both_cnt != 0) begin errors++; $display("FAIL strobe_overlap got=%0d exp=0", both_cnt); end
    checks++; if (dbl_cnt != 0) begin errors++; $display("FAIL strobe_width got=%0d exp=0", dbl_cnt); end
    checks++; if (act_err != 0) begin errors++; $display("FAIL active_vs_dv got=%0d exp=0", act_err); end
  endtask

  initial begin
    rx_if.i_RX_Serial = 1'b1;
    @(negedge clk);
    test_reset();
    test_single();
    test_back_to_back();
    test_start_glitch();
    test_break();
    test_reset_midframe();
    test_mid_glitch();
    test_random();
    test_strobe_rules();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
